// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pad synchronisers, glitch filters, 11-bit deframer,
// first-word-fall-through receive FIFO, sticky error flags and a level interrupt.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 24000
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          en_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_dat_i,
    input  logic                          rd_en_i,
    input  logic                          clr_i,
    output logic [7:0]                    dat_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
    output logic                          par_err_o,
    output logic                          frm_err_o,
    output logic                          ovf_o,
    output logic                          irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Index 0 is the PS/2 clock line, index 1 the data line.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         filt_q, filt_d;
    logic [1:0][FW-1:0] fcnt_q, fcnt_d;
    logic               filt_dly_q;
    logic               fe;
    logic               dat_f;

    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           par_q, par_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           push_q, push_d;
    logic           frm_set, par_set;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]    cnt;
    logic           empty, full, pop, push, ovf_set;
    logic           par_err_q, frm_err_q, ovf_q;

    // ---------------------------------------------------------------- input path
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            filt_dly_q <= 1'b1;
        end else begin
            sync1_q    <= {ps2_dat_i, ps2_clk_i};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            filt_dly_q <= filt_q[0];
        end
    end

    // A line only changes after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    assign fe    = filt_dly_q & ~filt_q[0];
    assign dat_f = filt_q[1];

    // ---------------------------------------------------------------- deframer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            push_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            push_q    <= push_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q + TW'(1);
        push_d    = 1'b0;
        frm_set   = 1'b0;
        par_set   = 1'b0;
        if (!en_i) begin
            state_d  = StIdle;
            to_cnt_d = '0;
        end else begin
            if (fe) begin
                to_cnt_d = '0;
            end
            unique case (state_q)
                StIdle: begin
                    to_cnt_d = '0;
                    if (fe) begin
                        if (!dat_f) begin
                            state_d   = StData;
                            bit_cnt_d = '0;
                        end else begin
                            frm_set = 1'b1;
                        end
                    end
                end
                StData: begin
                    if (fe) begin
                        shreg_d[bit_cnt_q] = dat_f;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StParity;
                        end
                    end
                end
                StParity: begin
                    if (fe) begin
                        par_d   = dat_f;
                        state_d = StStop;
                    end
                end
                StStop: begin
                    if (fe) begin
                        if (dat_f) begin
                            if (^{shreg_q, par_q}) begin
                                push_d = 1'b1;
                            end else begin
                                par_set = 1'b1;
                            end
                        end else begin
                            frm_set = 1'b1;
                        end
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
            // Inter-edge timeout abandons the partial frame.
            if (state_q != StIdle && !fe && to_cnt_q >= TW'(TIMEOUT_CYC - 1)) begin
                frm_set  = 1'b1;
                state_d  = StIdle;
                to_cnt_d = '0;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    assign cnt     = wr_ptr_q - rd_ptr_q;
    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW + 1)'(FIFO_DEPTH));
    assign pop     = rd_en_i & ~empty;
    assign push    = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
                wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (clr_i) begin
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            par_err_q <= par_err_q | par_set;
            frm_err_q <= frm_err_q | frm_set;
            ovf_q     <= ovf_q | ovf_set;
        end
    end

    assign dat_o     = mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o   = ~empty;
    assign cnt_o     = cnt;
    assign par_err_o = par_err_q;
    assign frm_err_o = frm_err_q;
    assign ovf_o     = ovf_q;
    assign irq_o     = valid_o | par_err_q | frm_err_q | ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: a keyboard model drives frames; a byte-level queue model of the
// FIFO and flags is compared against the DUT every settled cycle.
module tb_ps2_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned FILT  = 4;
    localparam int unsigned TMO   = 300;
    localparam int unsigned HALF  = 30;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       en_i = 1'b1;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic       rd_en_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [7:0] dat_o;
    logic       valid_o;
    logic [3:0] cnt_o;
    logic       par_err_o, frm_err_o, ovf_o, irq_o;

    ps2_rx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FILT_LEN   (FILT),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (en_i),
        .ps2_clk_i(ps2_clk_i),
        .ps2_dat_i(ps2_dat_i),
        .rd_en_i  (rd_en_i),
        .clr_i    (clr_i),
        .dat_o    (dat_o),
        .valid_o  (valid_o),
        .cnt_o    (cnt_o),
        .par_err_o(par_err_o),
        .frm_err_o(frm_err_o),
        .ovf_o    (ovf_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model: FIFO contents and sticky flags.
    byte unsigned q[$];
    bit m_par = 1'b0, m_frm = 1'b0, m_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_push(input byte unsigned b);
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(b);
    endfunction

    function automatic void m_frame(input byte unsigned b, input bit p, input bit stop);
        if (!stop) m_frm = 1'b1;
        else if (^{b, p}) m_push(b);
        else m_par = 1'b1;
    endfunction

    function automatic void m_clear();
        q.delete();
        m_par = 1'b0;
        m_frm = 1'b0;
        m_ovf = 1'b0;
    endfunction

    function automatic logic [10:0] mk(input byte unsigned b, input bit p, input bit stop);
        return {stop, p, b, 1'b0};
    endfunction

    always @(negedge clk_i) begin
        if (check_en) begin
            chk("valid", int'(valid_o), int'(q.size() != 0));
            chk("cnt", int'(cnt_o), q.size());
            if (q.size() != 0) chk("dat", int'(dat_o), int'(q[0]));
            chk("par_err", int'(par_err_o), int'(m_par));
            chk("frm_err", int'(frm_err_o), int'(m_frm));
            chk("ovf", int'(ovf_o), int'(m_ovf));
            chk("irq", int'(irq_o), int'((q.size() != 0) | m_par | m_frm | m_ovf));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Sends bits[0..n-1], one per PS/2 clock; optionally pulses rd_en_i in the push cycle.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_last);
        for (int i = 0; i < n; i++) begin
            ps2_dat_i = bits[i];
            step(HALF);
            ps2_clk_i = 1'b0;
            if (pop_last && i == n - 1) begin
                step(3 + FILT);
                rd_en_i = 1'b1;
                step(1);
                rd_en_i = 1'b0;
                step(HALF - 4 - FILT);
            end else begin
                step(HALF);
            end
            ps2_clk_i = 1'b1;
        end
        step(HALF);
        ps2_dat_i = 1'b1;
    endtask

    task automatic frame(input byte unsigned b, input bit p, input bit stop, input bit pop_last);
        check_en = 1'b0;
        send_bits(mk(b, p, stop), 11, pop_last);
        step(5);
        if (pop_last && q.size() != 0) void'(q.pop_front());
        m_frame(b, p, stop);
        check_en = 1'b1;
        step(2);
    endtask

    task automatic good(input byte unsigned b);
        frame(b, ~^b, 1'b1, 1'b0);
    endtask

    task automatic pop1();
        rd_en_i = 1'b1;
        step(1);
        rd_en_i = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        step(1);
    endtask

    task automatic clr1();
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        m_clear();
        step(1);
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        rst_n_i = 1'b0;
        step(3);
        rst_n_i = 1'b1;
        m_clear();
        step(2);
        check_en = 1'b1;
    endtask

    initial begin
        byte unsigned b;
        int k;
        step(3);
        rst_n_i = 1'b1;
        step(1);
        chk("rst_cnt", int'(cnt_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_dat", int'(dat_o), 0);
        chk("rst_irq", int'(irq_o), 0);
        chk("rst_flags", int'({par_err_o, frm_err_o, ovf_o}), 0);
        check_en = 1'b1;
        step(10);

        // Short clock glitches while idle must be invisible.
        repeat (3) begin
            ps2_clk_i = 1'b0;
            step(2);
            ps2_clk_i = 1'b1;
            step(20);
        end

        good(8'h41);
        chk("f41_dat", int'(dat_o), 8'h41);
        chk("f41_cnt", int'(cnt_o), 1);
        chk("f41_irq", int'(irq_o), 1);
        pop1();
        chk("f41_pop_valid", int'(valid_o), 0);
        chk("f41_pop_irq", int'(irq_o), 0);

        frame(8'h41, 1'b0, 1'b1, 1'b0);
        chk("badpar_flag", int'(par_err_o), 1);
        chk("badpar_cnt", int'(cnt_o), 0);
        clr1();
        chk("badpar_clr", int'(par_err_o), 0);

        frame(8'h5A, ~^8'h5A, 1'b0, 1'b0);
        chk("badstop_frm", int'(frm_err_o), 1);
        chk("badstop_cnt", int'(cnt_o), 0);
        clr1();

        // Start bit sampled high.
        check_en = 1'b0;
        send_bits(11'h001, 1, 1'b0);
        step(5);
        m_frm = 1'b1;
        check_en = 1'b1;
        step(2);
        clr1();

        // Clock stops after four data bits.
        check_en = 1'b0;
        send_bits(11'b000_0001_1000, 5, 1'b0);
        step(TMO + 50);
        m_frm = 1'b1;
        check_en = 1'b1;
        step(2);
        chk("tmo_frm", int'(frm_err_o), 1);
        good(8'h1C);
        chk("tmo_next_dat", int'(dat_o), 8'h1C);
        pop1();
        clr1();

        // Dropping the enable mid-frame discards silently.
        check_en = 1'b0;
        send_bits(mk(8'h6B, 1'b0, 1'b1), 4, 1'b0);
        en_i = 1'b0;
        step(5);
        en_i = 1'b1;
        step(5);
        check_en = 1'b1;
        step(TMO + 20);
        chk("en_frm", int'(frm_err_o), 0);
        good(8'h6B);
        pop1();

        for (int i = 0; i < 9; i++) good(byte'(8'h41 + i));
        chk("ovf_cnt", int'(cnt_o), 8);
        chk("ovf_flag", int'(ovf_o), 1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_order", int'(dat_o), 8'h41 + i);
            pop1();
        end
        clr1();
        for (int i = 0; i < 8; i++) good(byte'(8'h50 + i));
        frame(8'h58, ~^8'h58, 1'b1, 1'b1);
        chk("fullpp_cnt", int'(cnt_o), 8);
        chk("fullpp_ovf", int'(ovf_o), 0);
        chk("fullpp_head", int'(dat_o), 8'h51);
        while (q.size() != 0) pop1();

        // Reset in the middle of a frame.
        check_en = 1'b0;
        send_bits(mk(8'h33, ~^8'h33, 1'b1), 6, 1'b0);
        do_reset();
        good(8'h33);
        chk("rstmid_cnt", int'(cnt_o), 1);
        chk("rstmid_dat", int'(dat_o), 8'h33);
        chk("rstmid_err", int'({par_err_o, frm_err_o, ovf_o}), 0);
        pop1();

        for (int n = 0; n < 24; n++) begin
            b = byte'($urandom);
            k = $urandom_range(0, 9);
            if (k < 7) good(b);
            else if (k == 7) frame(b, ^b, 1'b1, 1'b0);
            else if (k == 8) frame(b, ~^b, 1'b0, 1'b0);
            else clr1();
            repeat ($urandom_range(0, 2)) pop1();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
